// File: rtl/ne_pkg.sv
// Shared neural-engine definitions: coeff buffer geometry, scheduler states
// and small sizing helpers used by the coefficient fetch path.
package ne_pkg;

    localparam int COEFF_ADDR_W = 9;
    localparam int COEFF_DATA_W = 512;
    localparam int SCHED_REP_W  = 8;
    localparam int SCHED_FIFO_D = 2;

    typedef logic [COEFF_DATA_W-1:0] coeff_row_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } ne_sched_state_t;

    // Width needed to hold an occupancy count of 0..depth inclusive.
    function automatic int ne_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ne_skid_fifo.sv
// Small synchronous FIFO with registered head and synchronous flush; used to
// absorb rows returned by the coeff buffer while the MAC array stalls.
module ne_skid_fifo
    import ne_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [WIDTH-1:0]             i_din,
    output logic [WIDTH-1:0]             o_dout,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_empty,
    output logic                         o_full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = ne_cnt_w(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic             w_doPush;
    logic             w_doPop;

    function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A push into a full FIFO only lands when the head leaves in the same cycle.
    assign w_doPop  = i_pop && !o_empty;
    assign w_doPush = i_push && (!o_full || w_doPop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_doPush && !i_flush) begin
            r_mem[r_wrPtr] <= i_din;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= ptrInc(r_wrPtr);
            end
            if (w_doPop) begin
                r_rdPtr <= ptrInc(r_rdPtr);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rdPtr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));

endmodule

// File: rtl/ne_coeff_sched.sv
// Coefficient fetch scheduler: walks a window of coeff buffer rows for a number
// of passes, reads them through the arbiter and streams them to the MAC array.
module ne_coeff_sched
    import ne_pkg::*;
#(
    parameter int ADDR_W = COEFF_ADDR_W,
    parameter int DATA_W = COEFF_DATA_W,
    parameter int REP_W  = SCHED_REP_W,
    parameter int FIFO_D = SCHED_FIFO_D
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [ADDR_W-1:0] i_cfg_base,
    input  logic [ADDR_W-1:0] i_cfg_rows,
    input  logic [REP_W-1:0]  i_cfg_reps,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic              o_rreq,
    input  logic              i_rack,
    output logic [ADDR_W-1:0] o_raddr,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_m_valid,
    input  logic              i_m_ready,
    output logic [DATA_W-1:0] o_m_data,
    output logic              o_m_last,
    output logic              o_m_final
);

    localparam int CNT_W  = ne_cnt_w(FIFO_D);
    localparam int FIFO_W = DATA_W + 2;

    ne_sched_state_t r_state;
    ne_sched_state_t w_nextState;

    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_rows;
    logic [ADDR_W-1:0] r_rowCnt;
    logic [ADDR_W-1:0] r_raddr;
    logic [REP_W-1:0]  r_reps;
    logic [REP_W-1:0]  r_repCnt;
    logic              r_inflight;
    logic              r_inflightLast;
    logic              r_inflightFinal;
    logic              r_emptyDone;
    logic              r_err;

    logic              w_cfgEmpty;
    logic              w_startIdle;
    logic              w_startOk;
    logic              w_pop;
    logic              w_rreq;
    logic              w_grant;
    logic              w_rowLast;
    logic              w_jobFinal;
    logic              w_finalHs;
    logic [CNT_W:0]    w_used;
    logic [FIFO_W-1:0] w_fifoDin;
    logic [FIFO_W-1:0] w_fifoDout;
    logic [CNT_W-1:0]  w_fifoCount;
    logic              w_fifoEmpty;
    logic              w_fifoFull;

    assign w_cfgEmpty  = (i_cfg_rows == '0) || (i_cfg_reps == '0);
    assign w_startIdle = i_start && !i_abort && (r_state == IDLE);
    assign w_startOk   = w_startIdle && !w_cfgEmpty;
    assign w_pop       = !w_fifoEmpty && i_m_ready;

    // Credits: a head leaving this cycle frees its slot for a request issued now,
    // which keeps one row per cycle flowing with a two-entry buffer.
    assign w_used  = (CNT_W+1)'(w_fifoCount) + (CNT_W+1)'(r_inflight) - (CNT_W+1)'(w_pop);
    assign w_rreq  = (r_state == FETCH) && (w_used < (CNT_W+1)'(FIFO_D));
    assign w_grant = w_rreq && i_rack && !i_abort;

    assign w_rowLast  = (r_rowCnt == (r_rows - ADDR_W'(1)));
    assign w_jobFinal = w_rowLast && (r_repCnt == (r_reps - REP_W'(1)));
    assign w_finalHs  = (r_state == DRAIN) && w_pop && w_fifoDout[0] && !i_abort;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        o_busy      = (r_state != IDLE);
        o_rreq      = w_rreq;
        o_done      = r_emptyDone || w_finalHs;
        if (i_abort) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_startOk) w_nextState = FETCH;
                FETCH:   if (w_grant && w_jobFinal) w_nextState = DRAIN;
                DRAIN:   if (w_finalHs) w_nextState = IDLE;
                default: w_nextState = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_base          <= '0;
            r_rows          <= '0;
            r_reps          <= '0;
            r_rowCnt        <= '0;
            r_repCnt        <= '0;
            r_raddr         <= '0;
            r_inflight      <= 1'b0;
            r_inflightLast  <= 1'b0;
            r_inflightFinal <= 1'b0;
            r_emptyDone     <= 1'b0;
            r_err           <= 1'b0;
        end else begin
            r_emptyDone     <= w_startIdle && w_cfgEmpty;
            r_err           <= i_start && !i_abort && (r_state != IDLE);
            r_inflight      <= w_grant;
            r_inflightLast  <= w_grant && w_rowLast;
            r_inflightFinal <= w_grant && w_jobFinal;
            if (w_startOk) begin
                r_base   <= i_cfg_base;
                r_rows   <= i_cfg_rows;
                r_reps   <= i_cfg_reps;
                r_rowCnt <= '0;
                r_repCnt <= '0;
                r_raddr  <= i_cfg_base;
            end else if (w_grant) begin
                if (w_rowLast) begin
                    r_rowCnt <= '0;
                    r_raddr  <= r_base;
                    r_repCnt <= r_repCnt + REP_W'(1);
                end else begin
                    r_rowCnt <= r_rowCnt + ADDR_W'(1);
                    r_raddr  <= r_raddr + ADDR_W'(1);
                end
            end
        end
    end

    // A returning row is captured unconditionally; the credit check above must
    // already have reserved its slot.
    always_ff @(posedge i_clk) begin
        if (!i_rst && !i_abort) begin
            assert (!(r_inflight && w_fifoFull && !w_pop));
        end
    end

    assign w_fifoDin = {i_rdata, r_inflightLast, r_inflightFinal};

    ne_skid_fifo #(
        .DEPTH (FIFO_D),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (i_abort),
        .i_push  (r_inflight),
        .i_pop   (w_pop),
        .i_din   (w_fifoDin),
        .o_dout  (w_fifoDout),
        .o_count (w_fifoCount),
        .o_empty (w_fifoEmpty),
        .o_full  (w_fifoFull)
    );

    assign o_err     = r_err;
    assign o_raddr   = r_raddr;
    assign o_m_valid = !w_fifoEmpty;
    assign o_m_data  = w_fifoDout[FIFO_W-1:2];
    assign o_m_last  = w_fifoDout[1];
    assign o_m_final = w_fifoDout[0];

endmodule

// File: tb/tb_ne_coeff_sched.sv
// Directed bench for the coefficient fetch scheduler: a coeff buffer model
// answers reads, and an expected-beat queue is compared against the MAC stream.
module tb_ne_coeff_sched;
    import ne_pkg::*;

    localparam int ADDR_W = COEFF_ADDR_W;
    localparam int DATA_W = COEFF_DATA_W;
    localparam int REP_W  = SCHED_REP_W;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
        logic              fin;
    } beat_t;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_start;
    logic              i_abort;
    logic [ADDR_W-1:0] i_cfg_base;
    logic [ADDR_W-1:0] i_cfg_rows;
    logic [REP_W-1:0]  i_cfg_reps;
    logic              o_busy;
    logic              o_done;
    logic              o_err;
    logic              o_rreq;
    logic              i_rack;
    logic [ADDR_W-1:0] o_raddr;
    logic [DATA_W-1:0] i_rdata = '0;
    logic              o_m_valid;
    logic              i_m_ready;
    logic [DATA_W-1:0] o_m_data;
    logic              o_m_last;
    logic              o_m_final;

    int    checks    = 0;
    int    errors    = 0;
    int    grants    = 0;
    int    doneCnt   = 0;
    int    doneCycle = 0;
    int    cycleCnt  = 0;
    beat_t expQ[$];

    always #5 i_clk = ~i_clk;

    ne_coeff_sched dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_abort    (i_abort),
        .i_cfg_base (i_cfg_base),
        .i_cfg_rows (i_cfg_rows),
        .i_cfg_reps (i_cfg_reps),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err),
        .o_rreq     (o_rreq),
        .i_rack     (i_rack),
        .o_raddr    (o_raddr),
        .i_rdata    (i_rdata),
        .o_m_valid  (o_m_valid),
        .i_m_ready  (i_m_ready),
        .o_m_data   (o_m_data),
        .o_m_last   (o_m_last),
        .o_m_final  (o_m_final)
    );

    function automatic coeff_row_t rowData(input logic [ADDR_W-1:0] a);
        return {16{{7'h51, 16'hC0EF, a}}};
    endfunction

    // Coeff buffer model: the granted row appears exactly one cycle after rack.
    always @(posedge i_clk) begin
        if (o_rreq && i_rack) begin
            i_rdata <= rowData(o_raddr);
        end else begin
            i_rdata <= '0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkBeat(input beat_t e);
        checks++;
        assert (o_m_data === e.data) else begin
            errors++;
            $error("[TB] FAIL beat_data: observed %h expected %h", o_m_data, e.data);
        end
        checkOutput("beat_last", 32'(o_m_last), 32'(e.last));
        checkOutput("beat_final", 32'(o_m_final), 32'(e.fin));
        checkOutput("beat_done", 32'(o_done), 32'(e.fin));
    endtask

    // Samples the cycle just before the falling edge: counts grants and done
    // pulses, and compares every handshaken beat against the expected queue.
    task automatic monitor();
        beat_t e;
        if (o_rreq && i_rack) grants++;
        if (o_done) begin
            doneCnt++;
            doneCycle = cycleCnt;
        end
        if (o_m_valid && i_m_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_beat", 32'(expQ.size()), 32'd1);
            end else begin
                e = expQ.pop_front();
                checkBeat(e);
            end
        end
    endtask

    task automatic tick();
        #3;
        monitor();
        @(posedge i_clk);
        #1;
        cycleCnt++;
    endtask

    task automatic applyStimulus(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] rows,
                                 input logic [REP_W-1:0] reps, input bit legal);
        beat_t e;
        logic [ADDR_W-1:0] a;
        i_cfg_base = base;
        i_cfg_rows = rows;
        i_cfg_reps = reps;
        i_start    = 1'b1;
        if (legal) begin
            for (int rep = 0; rep < int'(reps); rep++) begin
                for (int r = 0; r < int'(rows); r++) begin
                    a      = base + ADDR_W'(r);
                    e.data = rowData(a);
                    e.last = (r == int'(rows) - 1);
                    e.fin  = e.last && (rep == int'(reps) - 1);
                    expQ.push_back(e);
                end
            end
        end
        tick();
        i_start = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int limit);
        int d0;
        int n;
        d0 = doneCnt;
        n  = 0;
        while (doneCnt == d0 && n < limit) begin
            tick();
            n++;
        end
        checkOutput(tag, 32'(doneCnt - d0), 32'd1);
    endtask

    initial begin
        int g0;
        int d0;
        int startCycle;

        i_rst      = 1'b1;
        i_start    = 1'b0;
        i_abort    = 1'b0;
        i_cfg_base = '0;
        i_cfg_rows = '0;
        i_cfg_reps = '0;
        i_rack     = 1'b1;
        i_m_ready  = 1'b1;
        repeat (3) tick();
        i_rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_busy", 32'(o_busy), 32'd0);
        checkOutput("rst_done", 32'(o_done), 32'd0);
        checkOutput("rst_err", 32'(o_err), 32'd0);
        checkOutput("rst_rreq", 32'(o_rreq), 32'd0);
        checkOutput("rst_raddr", 32'(o_raddr), 32'd0);
        checkOutput("rst_m_valid", 32'(o_m_valid), 32'd0);
        checkOutput("rst_m_last", 32'(o_m_last), 32'd0);
        checkOutput("rst_m_final", 32'(o_m_final), 32'd0);
        checkOutput("rst_m_data", o_m_data[31:0], 32'd0);
        tick();

        $display("[TB] basic job base=10 rows=4 reps=1");
        applyStimulus(9'd10, 9'd4, 8'd1, 1'b1);
        startCycle = cycleCnt;
        checkOutput("basic_busy", 32'(o_busy), 32'd1);
        checkOutput("basic_first_raddr", 32'(o_raddr), 32'd10);
        waitDone("basic_done", 40);
        checkOutput("basic_latency", 32'(doneCycle - startCycle), 32'd5);
        checkOutput("basic_idle", 32'(o_busy), 32'd0);
        tick();

        $display("[TB] wrap and repeat base=510 rows=3 reps=2");
        applyStimulus(9'd510, 9'd3, 8'd2, 1'b1);
        waitDone("wrap_done", 60);
        checkOutput("wrap_idle", 32'(o_busy), 32'd0);
        tick();

        $display("[TB] back-pressure");
        i_m_ready = 1'b0;
        g0 = grants;
        applyStimulus(9'd40, 9'd4, 8'd2, 1'b1);
        repeat (20) tick();
        checkOutput("bp_grants", 32'(grants - g0), 32'd2);
        checkOutput("bp_rreq_low", 32'(o_rreq), 32'd0);
        checkOutput("bp_m_valid", 32'(o_m_valid), 32'd1);
        checkOutput("bp_head_data", o_m_data[31:0], expQ[0].data[31:0]);
        i_m_ready = 1'b1;
        waitDone("bp_done", 60);
        tick();

        $display("[TB] arbiter stall");
        i_rack = 1'b0;
        g0 = grants;
        applyStimulus(9'd100, 9'd3, 8'd1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            checkOutput("stall_rreq", 32'(o_rreq), 32'd1);
            checkOutput("stall_raddr", 32'(o_raddr), 32'd100);
            tick();
        end
        checkOutput("stall_grants", 32'(grants - g0), 32'd0);
        i_rack = 1'b1;
        waitDone("stall_done", 40);
        tick();

        $display("[TB] abort coinciding with rack");
        applyStimulus(9'd20, 9'd8, 8'd1, 1'b1);
        repeat (3) tick();
        checkOutput("abort_rreq_hi", 32'(o_rreq), 32'd1);
        i_abort = 1'b1;
        d0 = doneCnt;
        tick();
        checkOutput("abort_busy", 32'(o_busy), 32'd0);
        checkOutput("abort_m_valid", 32'(o_m_valid), 32'd0);
        checkOutput("abort_rreq", 32'(o_rreq), 32'd0);
        checkOutput("abort_done", 32'(o_done), 32'd0);
        i_abort = 1'b0;
        expQ.delete();
        repeat (3) tick();
        checkOutput("abort_no_done", 32'(doneCnt - d0), 32'd0);
        checkOutput("abort_still_empty", 32'(o_m_valid), 32'd0);
        applyStimulus(9'd0, 9'd2, 8'd1, 1'b1);
        waitDone("post_abort_done", 40);
        tick();

        $display("[TB] empty jobs");
        g0 = grants;
        applyStimulus(9'd5, 9'd0, 8'd3, 1'b1);
        checkOutput("empty_rows_done", 32'(o_done), 32'd1);
        checkOutput("empty_rows_busy", 32'(o_busy), 32'd0);
        checkOutput("empty_rows_rreq", 32'(o_rreq), 32'd0);
        tick();
        checkOutput("empty_done_pulse", 32'(o_done), 32'd0);
        applyStimulus(9'd5, 9'd3, 8'd0, 1'b1);
        checkOutput("empty_reps_done", 32'(o_done), 32'd1);
        checkOutput("empty_reps_busy", 32'(o_busy), 32'd0);
        repeat (3) tick();
        checkOutput("empty_grants", 32'(grants - g0), 32'd0);

        $display("[TB] start while busy");
        applyStimulus(9'd300, 9'd5, 8'd2, 1'b1);
        repeat (3) tick();
        applyStimulus(9'd7, 9'd1, 8'd1, 1'b0);
        checkOutput("busy_err", 32'(o_err), 32'd1);
        checkOutput("busy_still", 32'(o_busy), 32'd1);
        tick();
        checkOutput("busy_err_pulse", 32'(o_err), 32'd0);
        waitDone("busy_done", 80);
        checkOutput("busy_idle", 32'(o_busy), 32'd0);
        repeat (2) tick();

        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
